// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART state encoding, frame constants and helpers   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic int baud_cnt_max(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Width able to hold 0..max_val-1, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_if : byte valid/ready handshake into the UART transmitter    |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
interface uart_tx_if;
  logic [7:0] din;
  logic       din_vld;
  logic       rdy;

  modport master (output din, output din_vld, input rdy);
  modport slave  (input din, input din_vld, output rdy);
endinterface
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_baud_cnt : baud-period counter, pulses o_bit_end on last cycle  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CNT_MAX = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_bit_end
);

  localparam int CW = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);

  logic [CW-1:0] r_cnt;

  assign o_bit_end = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_bit_end) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx : 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN defined)  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD     = 115200
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  bus,
  output logic      o_tx
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD);

  uart_state_e          r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [2:0]           r_bit_cnt, w_bit_cnt_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_rdy;
  logic                 w_accept, w_busy, w_idle, w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 r_par, w_par_nxt;
`endif

  assign w_accept = bus.din_vld && r_rdy;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_busy   = !w_idle;

  uart_baud_cnt #(.CNT_MAX(BAUD_CNT_MAX)) u_baud_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_busy),
    .i_clr     (w_idle),
    .o_bit_end (w_bit_end)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_nxt      = 1'b1;
`ifdef UART_TX_PARITY_EN
    w_par_nxt     = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt   = ST_START;
          w_shift_nxt   = bus.din;
          w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
          w_par_nxt     = ^bus.din;
`endif
        end
      end
      ST_START: if (w_bit_end) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
          if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
            w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt   = ST_PARITY;
`else
            w_state_nxt   = ST_STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (w_bit_end) w_state_nxt = ST_STOP;
`endif
      ST_STOP: if (w_bit_end) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered line is aligned with it.
    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_nxt = w_par_nxt;
`endif
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
      r_rdy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_rdy     <= (w_state_nxt == ST_IDLE);
`ifdef UART_TX_PARITY_EN
      r_par     <= w_par_nxt;
`endif
    end
  end

  assign o_tx    = r_tx;
  assign bus.rdy = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx : self-checking bench for uart_tx at 10 cycles per bit    |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_uart_tx;

  localparam int BIT = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  int   total = 0;
  int   bad   = 0;

  uart_tx_if bus();

  uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .o_tx  (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Transmission order: bit 0 first (start), then data LSB first, parity, stop.
  function automatic logic [10:0] frame_from(input logic [7:0] b, input logic par);
`ifdef UART_TX_PARITY_EN
    return {1'b1, par, b, 1'b0};
`else
    return {1'b1, 1'b1, b, 1'b0};
`endif
  endfunction

  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int   ones;
    logic par;
    ones = 0;
    for (int k = 0; k < 8; k++) if (b[k]) ones++;
    par = ((ones % 2) == 1);
    return frame_from(b, par);
  endfunction

  // Called on the first negedge after the accepting edge.
  task automatic check_frame(input string tag, input logic [10:0] fr, input int poke_at,
                             input logic [7:0] poke_din, input bit poke_hold);
    for (int i = 0; i < FL * BIT; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "_tx"}, tx, fr[i / BIT]);
      chk({tag, "_rdy"}, bus.rdy, 1'b0);
      if (i == poke_at) begin
        bus.din     = poke_din;
        bus.din_vld = 1'b1;
      end else if (i == poke_at + 1 && !poke_hold) begin
        bus.din_vld = 1'b0;
        bus.din     = 8'hA5;
      end
    end
    @(negedge clk);
    chk({tag, "_idle_tx"}, tx, 1'b1);
    chk({tag, "_idle_rdy"}, bus.rdy, 1'b1);
  endtask

  task automatic send(input string tag, input logic [7:0] b, input logic [10:0] fr,
                      input int poke_at, input logic [7:0] poke_din, input bit poke_hold,
                      input bit hold);
    chk({tag, "_pre_rdy"}, bus.rdy, 1'b1);
    bus.din     = b;
    bus.din_vld = 1'b1;
    @(negedge clk);
    if (!hold) bus.din_vld = 1'b0;
    check_frame(tag, fr, poke_at, poke_din, poke_hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int         gap;

    vecs[0] = '{8'h4A, 1'b1};
    vecs[1] = '{8'h33, 1'b0};
    vecs[2] = '{8'h31, 1'b1};
    vecs[3] = '{8'h30, 1'b0};
    vecs[4] = '{8'h00, 1'b0};
    vecs[5] = '{8'hFF, 1'b0};
    vecs[6] = '{8'h80, 1'b1};
    vecs[7] = '{8'h7E, 1'b0};

    bus.din     = 8'h00;
    bus.din_vld = 1'b0;
    rst_n       = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_rdy", bus.rdy, 1'b1);
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("post_rst_tx", tx, 1'b1);
      chk("post_rst_rdy", bus.rdy, 1'b1);
    end

    send("single4a", 8'h4A, frame_from(8'h4A, 1'b1), -10, 8'h00, 1'b0, 1'b0);

    // A byte offered while busy must vanish, and din churn must not reach the line.
    send("drop", 8'h4A, frame_from(8'h4A, 1'b1), 30, 8'h31, 1'b0, 1'b0);
    repeat (15) begin
      @(negedge clk);
      chk("drop_quiet_tx", tx, 1'b1);
      chk("drop_quiet_rdy", bus.rdy, 1'b1);
    end

    send("b2b_a", 8'h33, frame_from(8'h33, 1'b0), 0, 8'h30, 1'b1, 1'b1);
    @(negedge clk);
    bus.din_vld = 1'b0;
    check_frame("b2b_b", frame_from(8'h30, 1'b0), -10, 8'h00, 1'b0);

    // Reset during data bit 3 of 8'h37 (that bit is 0, so the line visibly jumps high).
    chk("mid_pre_rdy", bus.rdy, 1'b1);
    bus.din     = 8'h37;
    bus.din_vld = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
    repeat (44) @(negedge clk);
    chk("mid_tx_bit3", tx, 1'b0);
    chk("mid_rdy_busy", bus.rdy, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_rdy", bus.rdy, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_tx", tx, 1'b1);
    chk("rel_rdy", bus.rdy, 1'b1);
    send("after_rst", 8'h5C, model_frame(8'h5C), -10, 8'h00, 1'b0, 1'b0);

    for (int v = 0; v < 8; v++) begin
      send($sformatf("vec%0d", v), vecs[v].din, frame_from(vecs[v].din, vecs[v].par),
           -10, 8'h00, 1'b0, 1'b0);
    end

    for (int r = 0; r < 6; r++) begin
      rb  = 8'($urandom);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("rnd_gap_tx", tx, 1'b1);
        chk("rnd_gap_rdy", bus.rdy, 1'b1);
      end
      send($sformatf("rnd%0d_%02h", r, rb), rb, model_frame(rb), -10, 8'h00, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
